// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES-128 MixColumns stage between ShiftRows and
// AddRoundKey. Mixes COLS_PER_CYCLE columns per busy cycle. A per-block bypass
// forwards the state unmixed for the final round.
// Optional feature macro: AES_INV_MIX_COLUMNS_EN adds an 'inv' port selecting
// InvMixColumns (coefficients 0E,0B,0D,09). Without the macro only the forward
// transform exists.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
`ifdef AES_INV_MIX_COLUMNS_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // Only 1, 2 or 4 columns per cycle divide the four-column state evenly.
  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] COLS_INC = 3'(COLS_PER_CYCLE);
  // col_cnt value of the busy cycle that covers column 3.
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [1:0]     col_cnt_r;
  logic [1:0]     col_cnt_nxt_s;
  logic [127:0]   data_r;
  logic [127:0]   result_r;
  logic [31:0]    mixed_s [4];
  logic [3:0]     win_s;
`ifdef AES_INV_MIX_COLUMNS_EN
  logic           inv_r;
`endif

  // GF(2^8) multiply by 2, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column; row 0 byte is the MSB.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
    b0 = xtime(a0); b1 = xtime(a1); b2 = xtime(a2); b3 = xtime(a3);
    return {b0 ^ (b1 ^ a1) ^ a2 ^ a3,
            a0 ^ b1 ^ (b2 ^ a2) ^ a3,
            a0 ^ a1 ^ b2 ^ (b3 ^ a3),
            (b0 ^ a0) ^ a1 ^ a2 ^ b3};
  endfunction

`ifdef AES_INV_MIX_COLUMNS_EN
  // Multiply by 9, 11, 13, 14 built from chained xtime; packed {m14,m13,m11,m9}.
  function automatic logic [31:0] inv_mults(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x4 ^ a, x8 ^ x2 ^ a, x8 ^ a};
  endfunction

  // InvMixColumns on one column.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_mults(col[31:24]);
    m1 = inv_mults(col[23:16]);
    m2 = inv_mults(col[15:8]);
    m3 = inv_mults(col[7:0]);
    // Fields: [31:24]=14a, [23:16]=13a, [15:8]=11a, [7:0]=9a
    return {m0[31:24] ^ m1[15:8]  ^ m2[23:16] ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[15:8]  ^ m3[23:16],
            m0[23:16] ^ m1[7:0]   ^ m2[31:24] ^ m3[15:8],
            m0[15:8]  ^ m1[23:16] ^ m2[7:0]   ^ m3[31:24]};
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; bypassed blocks skip the busy phase entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = in_bypass ? ST_DONE : ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (col_cnt_r == LAST_CNT) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_BUSY: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Per-column mix results and the window of columns handled this cycle.
  always_comb begin
    logic [1:0] off;
    col_cnt_nxt_s = 2'(({1'b0, col_cnt_r}) + COLS_INC);
    win_s = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      off = 2'(c) - col_cnt_r;
      win_s[c] = ({1'b0, off} < COLS_INC);
`ifdef AES_INV_MIX_COLUMNS_EN
      if (inv_r) begin
        mixed_s[c] = mix_inv(data_r[127-32*c -: 32]);
      end else begin
        mixed_s[c] = mix_fwd(data_r[127-32*c -: 32]);
      end
`else
      mixed_s[c] = mix_fwd(data_r[127-32*c -: 32]);
`endif
    end
  end

  // Datapath: latch on acceptance only, then fill the result column by column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= 128'd0;
      result_r  <= 128'd0;
      col_cnt_r <= 2'd0;
`ifdef AES_INV_MIX_COLUMNS_EN
      inv_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r    <= in_data;
            col_cnt_r <= 2'd0;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_r     <= inv;
`endif
            if (in_bypass) begin
              result_r <= in_data;
            end
          end
        end
        ST_BUSY: begin
          for (int c = 0; c < 4; c++) begin
            if (win_s[c]) begin
              result_r[127-32*c -: 32] <= mixed_s[c];
            end
          end
          // Wraps to 0 on the last busy cycle.
          col_cnt_r <= col_cnt_nxt_s;
        end
        default: begin
          col_cnt_r <= col_cnt_r;
        end
      endcase
    end
  end

  assign out_data = result_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed-vector bench. Three instances (1, 2 and 4
// columns per cycle) share the same inputs so every vector checks all widths.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_ready;
`ifdef AES_INV_MIX_COLUMNS_EN
  logic         inv;
`endif
  logic         iready [3];
  logic         ovalid [3];
  logic         bsy    [3];
  logic [127:0] odata  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (iready[g]),
        .in_data  (in_data),
        .in_bypass(in_bypass),
`ifdef AES_INV_MIX_COLUMNS_EN
        .inv      (inv),
`endif
        .out_valid(ovalid[g]),
        .out_ready(out_ready),
        .out_data (odata[g]),
        .busy     (bsy[g])
      );
    end
  endgenerate

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pack3(input logic a0, input logic a1, input logic a2);
    return {a2, a1, a0};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},  128'(pack3(iready[0], iready[1], iready[2])), 128'h7);
    check({tag, " out_valid"}, 128'(pack3(ovalid[0], ovalid[1], ovalid[2])), 128'h0);
    check({tag, " busy"},      128'(pack3(bsy[0], bsy[1], bsy[2])), 128'h0);
    for (int i = 0; i < 3; i++) check({tag, " out_data"}, odata[i], 128'h0);
  endtask

  // Send one state with out_ready high. Latency is counted in clock edges after
  // the accepting edge (0 = valid in the cycle right after acceptance).
  task automatic run_vec(input string tag, input logic [127:0] d, input logic byp,
                         input logic iv, input logic [127:0] exp,
                         input int l0, input int l1, input int l2);
    int lat [3];
    int nh  [3];
    int exp_lat [3];
    logic [127:0] cap [3];
    exp_lat = '{l0, l1, l2};
    @(negedge clk);
    check({tag, " idle ready"}, 128'(pack3(iready[0], iready[1], iready[2])), 128'h7);
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = byp;
`ifdef AES_INV_MIX_COLUMNS_EN
    inv       = iv;
`else
    if (iv) $display("note: inverse vector requested without inverse build");
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = 1'b0;
    check({tag, " busy after accept"}, 128'(pack3(bsy[0], bsy[1], bsy[2])), 128'h7);
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      nh[i]  = 0;
      cap[i] = 128'd0;
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (ovalid[i]) begin
          nh[i]++;
          if (lat[i] < 0) begin
            lat[i] = cyc;
            cap[i] = odata[i];
          end
        end
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s latency c%0d", tag, 1 << i), 128'(lat[i]), 128'(exp_lat[i]));
      check($sformatf("%s valid cycles c%0d", tag, 1 << i), 128'(nh[i]), 128'd1);
      check($sformatf("%s data c%0d", tag, 1 << i), cap[i], exp);
    end
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
`ifdef AES_INV_MIX_COLUMNS_EN
    inv       = 1'b0;
`endif
    @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Forward vectors: 4/2/1 busy cycles for 1/2/4 columns per cycle.
    run_vec("fwd1", 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 4, 2, 1);
    run_vec("fwd2", 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5, 1'b0, 1'b0,
            128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6, 4, 2, 1);
    // Bypass: result valid in the first cycle after the accepting edge.
    run_vec("byp", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0,
            128'h00112233_44556677_8899aabb_ccddeeff, 0, 0, 0);
`ifdef AES_INV_MIX_COLUMNS_EN
    run_vec("inv", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0, 1'b1,
            128'hdb135345_f20a225c_01010101_2d26314c, 4, 2, 1);
    inv = 1'b0;
`endif

    // Backpressure: hold out_ready low in DONE while pulsing in_valid.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 128'hdb135345_f20a225c_01010101_2d26314c;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      check("stall out_valid", 128'(pack3(ovalid[0], ovalid[1], ovalid[2])), 128'h7);
      check("stall in_ready",  128'(pack3(iready[0], iready[1], iready[2])), 128'h0);
      for (int i = 0; i < 3; i++)
        check("stall out_data", odata[i], 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      in_valid  = k[0];
      in_bypass = 1'b1;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", 128'(pack3(ovalid[0], ovalid[1], ovalid[2])), 128'h0);
    check("release in_ready",  128'(pack3(iready[0], iready[1], iready[2])), 128'h7);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ovalid[0] || ovalid[1] || ovalid[2]) seen = 1'b1;
    end
    check("single transfer", 128'(seen), 128'h0);

    // Reset during BUSY: the in-flight state must never appear.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre-reset busy", 128'(pack3(bsy[0], bsy[1], bsy[2])), 128'h7);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ovalid[0] || ovalid[1] || ovalid[2]) seen = 1'b1;
    end
    check("no emit after reset", 128'(seen), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
